// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: UART transmitter FSM states and MMIO register offsets.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package cpu_pkg;

    // Register offsets relative to a peripheral's base address
    localparam logic [15:0] REG_DATA_OFS = 16'd0;
    localparam logic [15:0] REG_CTRL_OFS = 16'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep count steady
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA register at BASE_ADDR queues bytes,
// CTRL register at BASE_ADDR+1 reports the FIFO count and clears overflow.
// Read data is registered and zero when unselected so it can be ORed with RAM.
// The read-data port is named dout because "do" is a SystemVerilog keyword.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module mmio_uart_tx
    import cpu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h0064,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    input  logic        we,
    output logic [7:0]  dout,
    output logic        tx
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] RELOAD  = BW'(CLKS_PER_BIT - 1);
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + REG_DATA_OFS;
    localparam logic [15:0] CTRL_ADDR = BASE_ADDR + REG_CTRL_OFS;

    tx_state_t     state;
    logic [7:0]    shreg;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic          ovf;
    logic          busy;
    logic          sel_data;
    logic          sel_ctrl;
    logic          pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign sel_data = (addr == DATA_ADDR);
    assign sel_ctrl = (addr == CTRL_ADDR);
    assign busy     = (state != IDLE) || !fifo_empty;
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && (bit_cnt == '0)));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (we && sel_data),
        .pop     (pop),
        .din     (di),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Serial framing FSM: start bit, 8 data bits LSB first, optional parity, stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= fifo_head;
                        state   <= START;
                        tx      <= 1'b0;
                        bit_cnt <= RELOAD;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_head;
`endif
                    end
                end
                START: begin
                    if (bit_cnt == '0) begin
                        state   <= DATA;
                        bit_cnt <= RELOAD;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == '0) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_cnt <= RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_cnt == '0) begin
                        if (!fifo_empty) begin
                            shreg   <= fifo_head;
                            state   <= START;
                            tx      <= 1'b0;
                            bit_cnt <= RELOAD;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_head;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow: set by a dropped push, cleared by any CTRL write
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (we && sel_data && fifo_full) begin
            ovf <= 1'b1;
        end else if (we && sel_ctrl) begin
            ovf <= 1'b0;
        end
    end

    // Registered read mux; zero when neither register is addressed
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else if (sel_data) begin
            dout <= {5'b0, ovf, fifo_full, busy};
        end else if (sel_ctrl) begin
            dout <= 8'(fifo_count);
        end else begin
            dout <= 8'h00;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN to select the 10- or 11-bit frame model.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  di = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  dout;
    logic        tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  di;
        logic        we;
        logic [7:0]  exp_do;
        logic        exp_tx;
    } vec_t;

    vec_t vecs [15];

    mmio_uart_tx #(
        .BASE_ADDR    (16'h0064),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .di   (di),
        .we   (we),
        .dout (dout),
        .tx   (tx)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of bus inputs, then step past the rising edge
    task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d, input logic w);
        addr = a;
        di   = d;
        we   = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(16'h0000, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    // Reference line level for bit slot idx of a frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Write one byte and follow its frame cycle by cycle, then confirm the return to idle
    task automatic send_and_check(input logic [7:0] b);
        apply_stimulus(16'h0064, b, 1'b1);
        check_output($sformatf("pre_start_%02h", b), {7'b0, tx}, 8'h01);
        for (int k = 0; k < FC; k++) begin
            apply_stimulus(16'h0064, 8'h00, 1'b0);
            check_output($sformatf("frame_%02h_k%0d", b, k), {7'b0, tx}, {7'b0, frame_bit(b, k / CPB)});
        end
        apply_stimulus(16'h0064, 8'h00, 1'b0);
        check_output($sformatf("busy_last_stop_%02h", b), dout, 8'h01);
        apply_stimulus(16'h0064, 8'h00, 1'b0);
        check_output($sformatf("idle_status_%02h", b), dout, 8'h00);
    endtask

    initial begin
        logic saw_low;

        // Register-access vectors: decode, status, count, overflow, clear
        vecs[0]  = '{16'h0066, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{16'h1234, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{16'h0064, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{16'h0065, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{16'h0064, 8'h11, 1'b1, 8'h00, 1'b1};
        vecs[5]  = '{16'h0064, 8'h22, 1'b1, 8'h01, 1'b0};
        vecs[6]  = '{16'h0064, 8'h33, 1'b1, 8'h01, 1'b0};
        vecs[7]  = '{16'h0064, 8'h44, 1'b1, 8'h01, 1'b0};
        vecs[8]  = '{16'h0064, 8'h55, 1'b1, 8'h01, 1'b0};
        vecs[9]  = '{16'h0064, 8'h66, 1'b1, 8'h03, 1'b1};
        vecs[10] = '{16'h0064, 8'h00, 1'b0, 8'h07, 1'b1};
        vecs[11] = '{16'h0065, 8'h00, 1'b0, 8'h04, 1'b1};
        vecs[12] = '{16'h0065, 8'hFF, 1'b1, 8'h04, 1'b1};
        vecs[13] = '{16'h0064, 8'h00, 1'b0, 8'h03, 1'b0};
        vecs[14] = '{16'h0066, 8'h00, 1'b0, 8'h00, 1'b0};

        // Reset state
        do_reset();
        check_output("reset_tx", {7'b0, tx}, 8'h01);
        check_output("reset_do", dout, 8'h00);

        $display("[TB] register vectors");
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].di, vecs[i].we);
            check_output($sformatf("vec%0d_do", i), dout, vecs[i].exp_do);
            check_output($sformatf("vec%0d_tx", i), {7'b0, tx}, {7'b0, vecs[i].exp_tx});
        end

        $display("[TB] single frame A5");
        do_reset();
        send_and_check(8'hA5);

        $display("[TB] back-to-back frames 01, 02");
        do_reset();
        apply_stimulus(16'h0064, 8'h01, 1'b1);
        check_output("b2b_pre_start", {7'b0, tx}, 8'h01);
        addr = 16'h0064;
        di   = 8'h02;
        we   = 1'b1;
        for (int k = 0; k < 2 * FC; k++) begin
            @(posedge clk);
            #1;
            we   = 1'b0;
            addr = 16'h0000;
            check_output($sformatf("b2b_k%0d", k), {7'b0, tx},
                         {7'b0, frame_bit((k < FC) ? 8'h01 : 8'h02, (k % FC) / CPB)});
        end
        apply_stimulus(16'h0000, 8'h00, 1'b0);
        apply_stimulus(16'h0064, 8'h00, 1'b0);
        check_output("b2b_idle_status", dout, 8'h00);

        $display("[TB] reset mid-frame with queued bytes");
        do_reset();
        apply_stimulus(16'h0064, 8'hC3, 1'b1);
        apply_stimulus(16'h0064, 8'h5A, 1'b1);
        apply_stimulus(16'h0064, 8'h0F, 1'b1);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(16'h0000, 8'h00, 1'b0);
        end
        apply_stimulus(16'h0065, 8'h00, 1'b0);
        check_output("midframe_bit3_tx", {7'b0, tx}, {7'b0, frame_bit(8'hC3, 4)});
        check_output("midframe_queued", dout, 8'h02);
        rst = 1'b1;
        apply_stimulus(16'h0065, 8'h00, 1'b0);
        rst = 1'b0;
        check_output("abort_tx", {7'b0, tx}, 8'h01);
        check_output("abort_do", dout, 8'h00);
        apply_stimulus(16'h0065, 8'h00, 1'b0);
        check_output("abort_count", dout, 8'h00);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(16'h0000, 8'h00, 1'b0);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check_output("abort_no_frames", {7'b0, saw_low}, 8'h00);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames 07, 03");
        do_reset();
        send_and_check(8'h07);
        do_reset();
        send_and_check(8'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
